// File: rtl/axis_seq_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module : axis_seq_gen_pkg
// Brief  : State encoding and width helper shared by the sequence generator.
// Rev    : 1.0
// ============================================================================
package axis_seq_gen_pkg;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    function automatic int keep_width(input int dwidth);
        return dwidth / 8;
    endfunction

endpackage
`default_nettype wire

// File: rtl/axis_seq_gen_ctr.sv
`default_nettype none
// ============================================================================
// Module : axis_seq_gen_ctr
// Brief  : Beat and packet counters; flags whether the next presented beat
//          closes the run or the packet.
// Rev    : 1.0
// ============================================================================
module axis_seq_gen_ctr
    import axis_seq_gen_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             adv_i,
    input  logic [CNT_W-1:0] num_beats_i,
    input  logic [CNT_W-1:0] pkt_len_i,
    output logic [CNT_W-1:0] beats_o,
    output logic             run_end_o,
    output logic             pkt_end_o
);

    logic [CNT_W-1:0] beats_q;
    logic [CNT_W-1:0] pkt_q;
    logic [CNT_W-1:0] nb_q;
    logic [CNT_W-1:0] plen_q;
    logic [CNT_W-1:0] plen_eff;
    logic [CNT_W-1:0] pkt_d;

    assign plen_eff = (pkt_len_i == '0) ? CNT_W'(1) : pkt_len_i;
    assign pkt_d    = (pkt_q == plen_q - CNT_W'(1)) ? '0 : pkt_q + CNT_W'(1);
    assign beats_o  = beats_q;

    // Flags describe beat 0 while loading, otherwise the beat after the current one.
    always_comb begin
        run_end_o = 1'b0;
        pkt_end_o = 1'b0;
        if (clr_i) begin
            run_end_o = (num_beats_i == CNT_W'(1));
            pkt_end_o = (plen_eff == CNT_W'(1));
        end else begin
            run_end_o = (beats_q + CNT_W'(1) == nb_q - CNT_W'(1));
            pkt_end_o = (pkt_d == plen_q - CNT_W'(1));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            beats_q <= '0;
            pkt_q   <= '0;
            nb_q    <= '0;
            plen_q  <= CNT_W'(1);
        end else if (clr_i) begin
            beats_q <= '0;
            pkt_q   <= '0;
            nb_q    <= num_beats_i;
            plen_q  <= plen_eff;
        end else if (adv_i) begin
            beats_q <= beats_q + CNT_W'(1);
            pkt_q   <= pkt_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/axis_seq_gen.sv
`default_nettype none
// ============================================================================
// Module : axis_seq_gen
// Brief  : AXI4-Stream source emitting seed+i beats with periodic tlast.
// Rev    : 1.0
// ============================================================================
module axis_seq_gen
    import axis_seq_gen_pkg::*;
#(
    parameter int DWIDTH = 16,
    parameter int CNT_W  = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          stop,
    input  logic [CNT_W-1:0]              num_beats,
    input  logic [CNT_W-1:0]              pkt_len,
    input  logic [DWIDTH-1:0]             seed,
    output logic                          busy,
    output logic                          done,
    output logic [CNT_W-1:0]              beats_sent,
    output logic                          m_dout_tvalid,
    input  logic                          m_dout_tready,
    output logic [DWIDTH-1:0]             m_dout_tdata,
    output logic [keep_width(DWIDTH)-1:0] m_dout_tkeep,
    output logic                          m_dout_tlast
);

    logic [1:0]        state_q;
    logic              tvalid_q;
    logic              tlast_q;
    logic [DWIDTH-1:0] tdata_q;
    logic              final_q;
    logic              stop_pend_q;
    logic              busy_q;
    logic              done_q;

    logic              start_ok;
    logic              hs;
    logic              stop_seen;
    logic              run_end;
    logic              pkt_end;

    assign start_ok  = (state_q == S_IDLE) && start;
    assign hs        = (state_q == S_RUN) && tvalid_q && m_dout_tready;
    assign stop_seen = stop_pend_q | stop;

    axis_seq_gen_ctr #(
        .CNT_W (CNT_W)
    ) u_ctr (
        .clk         (clk),
        .rst         (rst),
        .clr_i       (start_ok),
        .adv_i       (hs),
        .num_beats_i (num_beats),
        .pkt_len_i   (pkt_len),
        .beats_o     (beats_sent),
        .run_end_o   (run_end),
        .pkt_end_o   (pkt_end)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            tvalid_q    <= 1'b0;
            tlast_q     <= 1'b0;
            tdata_q     <= '0;
            final_q     <= 1'b0;
            stop_pend_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        busy_q      <= 1'b1;
                        stop_pend_q <= 1'b0;
                        if (num_beats != '0) begin
                            state_q  <= S_RUN;
                            tvalid_q <= 1'b1;
                            tdata_q  <= seed;
                            tlast_q  <= run_end | pkt_end;
                            final_q  <= run_end;
                        end else begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (hs) begin
                        stop_pend_q <= 1'b0;
                        if (final_q) begin
                            state_q  <= S_DONE;
                            tvalid_q <= 1'b0;
                            tlast_q  <= 1'b0;
                            done_q   <= 1'b1;
                        end else begin
                            // A pending stop only shapes the next beat; the stalled one stays intact.
                            tdata_q <= tdata_q + DWIDTH'(1);
                            tlast_q <= run_end | pkt_end | stop_seen;
                            final_q <= run_end | stop_seen;
                        end
                    end else begin
                        stop_pend_q <= stop_seen;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q  <= S_IDLE;
                    tvalid_q <= 1'b0;
                    tlast_q  <= 1'b0;
                    busy_q   <= 1'b0;
                end
            endcase
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign m_dout_tvalid = tvalid_q;
    assign m_dout_tdata  = tdata_q;
    assign m_dout_tlast  = tlast_q;
    assign m_dout_tkeep  = '1;

endmodule
`default_nettype wire

// File: tb/tb_axis_seq_gen.sv
`default_nettype none
// ============================================================================
// Module : tb_axis_seq_gen
// Brief  : Directed vector bench for axis_seq_gen.
// Rev    : 1.0
// ============================================================================
module tb_axis_seq_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [15:0] num_beats = '0;
    logic [15:0] pkt_len = '0;
    logic [15:0] seed = '0;
    logic        busy;
    logic        done;
    logic [15:0] beats_sent;
    logic        m_dout_tvalid;
    logic        m_dout_tready = 1'b0;
    logic [15:0] m_dout_tdata;
    logic [1:0]  m_dout_tkeep;
    logic        m_dout_tlast;

    always #5 clk = ~clk;

    axis_seq_gen #(
        .DWIDTH (16),
        .CNT_W  (16)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .stop          (stop),
        .num_beats     (num_beats),
        .pkt_len       (pkt_len),
        .seed          (seed),
        .busy          (busy),
        .done          (done),
        .beats_sent    (beats_sent),
        .m_dout_tvalid (m_dout_tvalid),
        .m_dout_tready (m_dout_tready),
        .m_dout_tdata  (m_dout_tdata),
        .m_dout_tkeep  (m_dout_tkeep),
        .m_dout_tlast  (m_dout_tlast)
    );

    typedef struct {
        logic [15:0] seed;
        logic [15:0] nb;
        logic [15:0] plen;
        int          beats;
    } scen_t;

    typedef struct {
        int          scn;
        int          idx;
        logic [15:0] data;
        logic        last;
    } beat_t;

    scen_t scen [4];
    beat_t bt   [13];

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [15:0] cap_data [256];
    logic        cap_last [256];
    int          n_cap;
    int          n_done;
    int          done_cyc;
    int          first_valid;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input logic [15:0] sd, input logic [15:0] n, input logic [15:0] pl,
                       input int rdy_pct, input int stop_at, input int max_cyc);
        logic        stalled;
        logic        stop_done;
        logic        r;
        logic        ended;
        logic [15:0] hd;
        logic        hl;
        stalled = 1'b0; stop_done = 1'b0; ended = 1'b0; hd = '0; hl = 1'b0;
        n_cap = 0; n_done = 0; done_cyc = -1; first_valid = -1;
        seed = sd; num_beats = n; pkt_len = pl; start = 1'b1;
        cyc();
        start = 1'b0;
        for (int c = 0; c < max_cyc && !ended; c++) begin
            if (stalled) begin
                chk("stall_valid", 32'(m_dout_tvalid), 32'd1);
                chk("stall_data", 32'(m_dout_tdata), 32'(hd));
                chk("stall_last", 32'(m_dout_tlast), 32'(hl));
            end
            if (m_dout_tvalid && first_valid < 0) first_valid = c;
            if (done) begin
                n_done++;
                done_cyc = c;
                ended = 1'b1;
            end
            r = ($urandom_range(99) < 32'(rdy_pct));
            stop = 1'b0;
            if (stop_at == n_cap && m_dout_tvalid && !stop_done) begin
                r = 1'b0; stop = 1'b1; stop_done = 1'b1;
            end
            m_dout_tready = r;
            stalled = 1'b0;
            if (m_dout_tvalid && r) begin
                if (n_cap < 256) begin
                    cap_data[n_cap] = m_dout_tdata;
                    cap_last[n_cap] = m_dout_tlast;
                end
                n_cap++;
            end else if (m_dout_tvalid) begin
                stalled = 1'b1; hd = m_dout_tdata; hl = m_dout_tlast;
            end
            cyc();
        end
        stop = 1'b0;
        m_dout_tready = 1'b0;
        chk("run_done_seen", 32'(n_done), 32'd1);
        chk("done_one_cycle", 32'(done), 32'd0);
        chk("idle_after_run", 32'(busy), 32'd0);
    endtask

    task automatic compare_scen(input int s);
        chk("scen_beats", 32'(n_cap), 32'(scen[s].beats));
        chk("scen_beats_sent", 32'(beats_sent), 32'(scen[s].beats));
        chk("scen_first_valid", 32'(first_valid), 32'd0);
        chk("scen_done_cycle", 32'(done_cyc), 32'(scen[s].beats));
        for (int i = 0; i < 13; i++) begin
            if (bt[i].scn == s) begin
                chk($sformatf("s%0d_b%0d_data", s, bt[i].idx), 32'(cap_data[bt[i].idx]), 32'(bt[i].data));
                chk($sformatf("s%0d_b%0d_last", s, bt[i].idx), 32'(cap_last[bt[i].idx]), 32'(bt[i].last));
            end
        end
    endtask

    initial begin
        int nl;
        scen[0] = '{16'h00FE, 16'd5, 16'd2, 5};
        scen[1] = '{16'hFFFE, 16'd4, 16'd4, 4};
        scen[2] = '{16'h1234, 16'd1, 16'd0, 1};
        scen[3] = '{16'h0010, 16'd3, 16'd0, 3};
        bt[0]  = '{0, 0, 16'h00FE, 1'b0};
        bt[1]  = '{0, 1, 16'h00FF, 1'b1};
        bt[2]  = '{0, 2, 16'h0100, 1'b0};
        bt[3]  = '{0, 3, 16'h0101, 1'b1};
        bt[4]  = '{0, 4, 16'h0102, 1'b1};
        bt[5]  = '{1, 0, 16'hFFFE, 1'b0};
        bt[6]  = '{1, 1, 16'hFFFF, 1'b0};
        bt[7]  = '{1, 2, 16'h0000, 1'b0};
        bt[8]  = '{1, 3, 16'h0001, 1'b1};
        bt[9]  = '{2, 0, 16'h1234, 1'b1};
        bt[10] = '{3, 0, 16'h0010, 1'b1};
        bt[11] = '{3, 1, 16'h0011, 1'b1};
        bt[12] = '{3, 2, 16'h0012, 1'b1};

        repeat (3) cyc();
        chk("rst_tvalid", 32'(m_dout_tvalid), 32'd0);
        chk("rst_tlast", 32'(m_dout_tlast), 32'd0);
        chk("rst_tdata", 32'(m_dout_tdata), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_beats_sent", 32'(beats_sent), 32'd0);
        chk("tkeep_ones", 32'(m_dout_tkeep), 32'h3);
        rst = 1'b0;
        cyc();

        for (int s = 0; s < 4; s++) begin
            run(scen[s].seed, scen[s].nb, scen[s].plen, 100, -1, 50);
            compare_scen(s);
        end

        // Random back-pressure at roughly 30% ready.
        run(16'h0100, 16'd64, 16'd8, 30, -1, 3000);
        chk("rnd_beats", 32'(n_cap), 32'd64);
        chk("rnd_beats_sent", 32'(beats_sent), 32'd64);
        nl = 0;
        for (int i = 0; i < 64; i++) begin
            chk($sformatf("rnd_data_%0d", i), 32'(cap_data[i]), 32'(16'(16'h0100 + i)));
            chk($sformatf("rnd_last_%0d", i), 32'(cap_last[i]), 32'((i % 8) == 7));
            if (cap_last[i]) nl++;
        end
        chk("rnd_tlast_count", 32'(nl), 32'd8);

        // Stop raised while beat 10 is stalled.
        run(16'h0500, 16'd100, 16'd16, 100, 10, 500);
        chk("stop_beats", 32'(n_cap), 32'd12);
        chk("stop_beats_sent", 32'(beats_sent), 32'd12);
        for (int i = 0; i < 11; i++)
            chk($sformatf("stop_last_%0d", i), 32'(cap_last[i]), 32'd0);
        chk("stop_b10_data", 32'(cap_data[10]), 32'h050A);
        chk("stop_b11_data", 32'(cap_data[11]), 32'h050B);
        chk("stop_b11_last", 32'(cap_last[11]), 32'd1);

        // Zero-length run.
        run(16'h0000, 16'd0, 16'd3, 100, -1, 20);
        chk("zero_no_valid", 32'(first_valid), 32'hFFFF_FFFF);
        chk("zero_done_cycle", 32'(done_cyc), 32'd0);
        chk("zero_beats", 32'(n_cap), 32'd0);
        chk("zero_beats_sent", 32'(beats_sent), 32'd0);

        // Start pulses in RUN and DONE must be ignored.
        seed = 16'h0700; num_beats = 16'd2; pkt_len = 16'd0; start = 1'b1; m_dout_tready = 1'b1;
        cyc();
        chk("ign_b0_data", 32'(m_dout_tdata), 32'h0700);
        seed = 16'h0000; num_beats = 16'd9; start = 1'b1;
        cyc();
        start = 1'b0;
        chk("ign_b1_data", 32'(m_dout_tdata), 32'h0701);
        chk("ign_b1_last", 32'(m_dout_tlast), 32'd1);
        cyc();
        chk("ign_done", 32'(done), 32'd1);
        start = 1'b1;
        cyc();
        start = 1'b0;
        chk("ign_idle_valid", 32'(m_dout_tvalid), 32'd0);
        chk("ign_idle_busy", 32'(busy), 32'd0);
        chk("ign_beats_sent", 32'(beats_sent), 32'd2);
        cyc();
        chk("ign_still_idle", 32'(busy), 32'd0);

        // Reset in the middle of a run.
        seed = 16'h3000; num_beats = 16'd50; pkt_len = 16'd4; start = 1'b1; m_dout_tready = 1'b1;
        cyc();
        start = 1'b0;
        cyc();
        cyc();
        chk("pre_rst_beats", 32'(beats_sent), 32'd2);
        chk("pre_rst_data", 32'(m_dout_tdata), 32'h3002);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        m_dout_tready = 1'b0;
        chk("mid_rst_valid", 32'(m_dout_tvalid), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_beats", 32'(beats_sent), 32'd0);
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        run(scen[0].seed, scen[0].nb, scen[0].plen, 100, -1, 50);
        compare_scen(0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire
